// File: rtl/spi_xip_seq.sv
// Execute-in-place read sequencer: issues one 64-bit SPI read (cmd 0x03 + addr) through a Wishbone SPI master.
// Optional macro SPI_XIP_BSWAP_EN byte-swaps the returned RX0 word.
module spi_xip_seq #(
    parameter logic [31:0] DIVIDER  = 32'h1,
    parameter logic [31:0] SS_MASK  = 32'h1,
    parameter int          POLL_MAX = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  state_dbg
);

    // Handshakes: req and rsp transfer on the rising edge where valid && ready are both high;
    // valid-side payload holds steady until that edge, and ready never depends on valid.
    typedef enum logic [3:0] {
        IDLE, WR_TX1, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX0, CLR_SS, RESP
    } state_t;

    localparam logic [9:0] POLL_LIMIT = 10'(POLL_MAX);

    state_t      state;
    logic [23:0] addr_q;
    logic [9:0]  poll_cnt;
    logic [31:0] data_q;
    logic        err_q;

    logic [4:0]  bus_adr;
    logic [31:0] bus_dat;
    logic        bus_we;

    // Fixed access fields for the bus state currently being entered
    always_comb begin
        bus_adr = 5'h00;
        bus_dat = 32'h0;
        bus_we  = 1'b0;
        case (state)
            WR_TX1:  begin bus_adr = 5'h04; bus_dat = {8'h03, addr_q}; bus_we = 1'b1; end
            WR_DIV:  begin bus_adr = 5'h14; bus_dat = DIVIDER;         bus_we = 1'b1; end
            WR_SS:   begin bus_adr = 5'h18; bus_dat = SS_MASK;         bus_we = 1'b1; end
            WR_CTRL: begin bus_adr = 5'h10; bus_dat = 32'h0000_0140;   bus_we = 1'b1; end
            POLL:    begin bus_adr = 5'h10; end
            RD_RX0:  begin bus_adr = 5'h00; end
            CLR_SS:  begin bus_adr = 5'h18; bus_dat = 32'h0;           bus_we = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= 24'h0;
            poll_cnt  <= 10'h0;
            data_q    <= 32'h0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            wb_adr_o  <= 5'h0;
            wb_dat_o  <= 32'h0;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        poll_cnt  <= 10'h0;
                        data_q    <= 32'h0;
                        err_q     <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= WR_TX1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    // Idle bus cycle first (the mandatory gap), then hold the access until acked
                    if (!wb_stb_o) begin
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        wb_adr_o <= bus_adr;
                        wb_dat_o <= bus_dat;
                        wb_we_o  <= bus_we;
                        wb_sel_o <= bus_we ? 4'hF : 4'h0;
                    end else if (wb_ack_i) begin
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_adr_o <= 5'h0;
                        wb_dat_o <= 32'h0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 4'h0;
                        case (state)
                            WR_TX1:  state <= WR_DIV;
                            WR_DIV:  state <= WR_SS;
                            WR_SS:   state <= WR_CTRL;
                            WR_CTRL: state <= POLL;
                            POLL: begin
                                if (!wb_dat_i[8]) begin
                                    state <= RD_RX0;
                                end else if (poll_cnt == POLL_LIMIT) begin
                                    err_q  <= 1'b1;
                                    data_q <= 32'h0;
                                    state  <= CLR_SS;
                                end else if (poll_cnt != 10'h3FF) begin
                                    poll_cnt <= poll_cnt + 10'h1;
                                end
                            end
                            RD_RX0: begin
                                data_q <= wb_dat_i;
                                state  <= CLR_SS;
                            end
                            CLR_SS: begin
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef SPI_XIP_BSWAP_EN
    assign rsp_data = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
`else
    assign rsp_data = data_q;
`endif
    assign rsp_err   = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_xip_seq.sv
// Directed bench for spi_xip_seq: Wishbone SPI-master model, access and response scoreboards.
module tb_spi_xip_seq;

    localparam logic [31:0] DIV  = 32'h0000_0005;
    localparam logic [31:0] SSM  = 32'h0000_0001;
    localparam int          PMAX = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [23:0] req_addr;
    logic [31:0] rsp_data;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o, state_dbg;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

    spi_xip_seq #(.DIVIDER(DIV), .SS_MASK(SSM), .POLL_MAX(PMAX)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .state_dbg(state_dbg)
    );

    // ---------------- Wishbone slave model ----------------
    logic        ack_en, stray_ack;
    logic [31:0] rx_word;
    int          busy_polls;
    int          poll_seen = 0;
    int          poll_base;
    logic        is_poll;

    assign is_poll  = wb_stb_o & wb_cyc_o & !wb_we_o & (wb_adr_o == 5'h10);
    assign wb_ack_i = (wb_stb_o & wb_cyc_o & ack_en) | stray_ack;
    assign wb_dat_i = is_poll ? (((poll_seen - poll_base) < busy_polls) ? 32'h0000_0140 : 32'h0000_0040)
                    : ((wb_adr_o == 5'h00) ? rx_word : 32'hDEAD_BEEF);

    always @(posedge clock) if (is_poll && wb_ack_i) poll_seen <= poll_seen + 1;

    // ---------------- scoreboard ----------------
    int          tests = 0;
    int          fails = 0;
    logic [41:0] exp_q[$];
    logic [32:0] rsp_q[$];
    logic [41:0] obs_acc, exp_acc;

    function automatic logic [41:0] acc(input logic we, input logic [4:0] adr, input logic [31:0] dat);
        return {we, adr, we ? dat : 32'h0, we ? 4'hF : 4'h0};
    endfunction

    function automatic logic [31:0] swap(input logic [31:0] d);
`ifdef SPI_XIP_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Each acked bus access is checked against the expected access sequence
    always @(negedge clock) begin
        if (!reset && wb_stb_o && wb_cyc_o && ack_en) begin
            obs_acc = {wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0, wb_sel_o};
            exp_acc = (exp_q.size() != 0) ? exp_q.pop_front() : 42'h3FF_FFFF_FFFF;
            tests++;
            assert (obs_acc === exp_acc)
            else begin
                fails++;
                $error("FAIL access obs=%h exp=%h", obs_acc, exp_acc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_txn(input logic [23:0] a, input int polls, input logic tmo, input logic [31:0] rx);
        exp_q.push_back(acc(1'b1, 5'h04, {8'h03, a}));
        exp_q.push_back(acc(1'b1, 5'h14, DIV));
        exp_q.push_back(acc(1'b1, 5'h18, SSM));
        exp_q.push_back(acc(1'b1, 5'h10, 32'h0000_0140));
        for (int i = 0; i < polls; i++) exp_q.push_back(acc(1'b0, 5'h10, 32'h0));
        if (!tmo) exp_q.push_back(acc(1'b0, 5'h00, 32'h0));
        exp_q.push_back(acc(1'b1, 5'h18, 32'h0));
        rsp_q.push_back(tmo ? {1'b1, 32'h0} : {1'b0, swap(rx)});
    endtask

    // Returns at the negedge following the accepting edge, with req_valid dropped
    task automatic issue(input logic [23:0] a);
        int n;
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("accept_timeout", {63'h0, req_ready}, 64'h1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 3000) begin
            @(negedge clock);
            lat++;
        end
        chk("rsp_timeout", {63'h0, rsp_valid}, 64'h1);
    endtask

    task automatic take_rsp(input string tag);
        logic [32:0] e;
        e = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'h1_FFFF_FFFF;
        chk({tag, "_data"}, {32'h0, rsp_data}, {32'h0, e[31:0]});
        chk({tag, "_err"}, {63'h0, rsp_err}, {63'h0, e[32]});
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, {60'h0, state_dbg}, 64'h0);
    endtask

    task automatic run_txn(input string tag, input logic [23:0] a, input int busy,
                           input logic tmo, input int polls, input logic [31:0] rx);
        int lat;
        busy_polls = busy;
        rx_word    = rx;
        poll_base  = poll_seen;
        push_txn(a, polls, tmo, rx);
        issue(a);
        wait_rsp(lat);
        take_rsp(tag);
        chk({tag, "_polls"}, 64'(poll_seen - poll_base), 64'(polls));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          lat, n;
        logic [31:0] held_data;
        logic        seen;

        reset = 1'b1; req_valid = 1'b0; req_addr = 24'h0; rsp_ready = 1'b0;
        ack_en = 1'b1; stray_ack = 1'b0; rx_word = 32'h0; busy_polls = 0; poll_base = 0;
        repeat (3) @(negedge clock);
        chk("rst_state", {60'h0, state_dbg}, 64'h0);
        chk("rst_stb_cyc", {62'h0, wb_stb_o, wb_cyc_o}, 64'h0);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_rsp", {31'h0, rsp_valid, rsp_err, rsp_data}, 64'h0);
        reset = 1'b0;

        // A stray ack while idle does nothing
        @(negedge clock); stray_ack = 1'b1;
        @(negedge clock); stray_ack = 1'b0;
        chk("stray_state", {60'h0, state_dbg}, 64'h0);
        chk("stray_stb", {63'h0, wb_stb_o}, 64'h0);

        // Minimum-latency read at 0x000100: one poll, 14 cycles to rsp_valid
        busy_polls = 0; rx_word = 32'hCAFE_F00D; poll_base = poll_seen;
        push_txn(24'h000100, 1, 1'b0, 32'hCAFE_F00D);
        issue(24'h000100);
        wait_rsp(lat);
        chk("min_latency", 64'(lat - 1), 64'd14);
        take_rsp("basic");
        chk("basic_polls", 64'(poll_seen - poll_base), 64'd1);

        // Busy for three polls, then ready
        run_txn("busy3", 24'h123456, 3, 1'b0, 4, 32'h1122_3344);

        // Permanently busy: POLL_MAX+1 polls, then error with zero data
        run_txn("timeout", 24'hABCDEF, 100000, 1'b1, PMAX + 1, 32'h5555_AAAA);

        // Back-pressured response with a second request waiting
        busy_polls = 2; rx_word = 32'h0BAD_F00D; poll_base = poll_seen;
        push_txn(24'h0000F0, 3, 1'b0, 32'h0BAD_F00D);
        push_txn(24'h00F000, 3, 1'b0, 32'h7654_3210);
        issue(24'h0000F0);
        req_valid = 1'b1; req_addr = 24'h00F000;
        wait_rsp(lat);
        held_data = rsp_data;
        chk("bp_first_data", {32'h0, held_data}, {32'h0, swap(32'h0BAD_F00D)});
        repeat (10) begin
            @(negedge clock);
            chk("bp_stable", {30'h0, rsp_valid, req_ready, rsp_err, rsp_data}, {30'h0, 1'b1, 1'b0, 1'b0, held_data});
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        void'(rsp_q.pop_front());
        chk("bp_after_hs", {59'h0, state_dbg, req_ready}, {59'h0, 4'd0, 1'b1});
        poll_base = poll_seen; rx_word = 32'h7654_3210;
        @(negedge clock);
        req_valid = 1'b0;
        chk("bp_second_acc", {59'h0, state_dbg, req_ready}, {59'h0, 4'd1, 1'b0});
        wait_rsp(lat);
        take_rsp("bp_second");
        chk("bp_second_polls", 64'(poll_seen - poll_base), 64'd3);

        // A few randomised reads
        for (int i = 0; i < 3; i++) begin
            int          b;
            logic [31:0] r;
            logic [23:0] a;
            b = $urandom_range(0, 3);
            r = $urandom;
            a = 24'($urandom);
            run_txn("rand", a, b, 1'b0, b + 1, r);
        end

        // Reset during WR_CTRL with the ack withheld
        busy_polls = 0; poll_base = poll_seen;
        exp_q.push_back(acc(1'b1, 5'h04, {8'h03, 24'h000200}));
        exp_q.push_back(acc(1'b1, 5'h14, DIV));
        exp_q.push_back(acc(1'b1, 5'h18, SSM));
        issue(24'h000200);
        n = 0;
        while (state_dbg != 4'd4 && n < 200) begin
            @(negedge clock);
            n++;
        end
        ack_en = 1'b0;
        @(negedge clock);
        chk("ctrl_pending", {58'h0, state_dbg, wb_stb_o, wb_we_o}, {58'h0, 4'd4, 1'b1, 1'b1});
        reset = 1'b1;
        #1;
        chk("rst_mid_stb_cyc", {62'h0, wb_stb_o, wb_cyc_o}, 64'h0);
        chk("rst_mid_state", {59'h0, state_dbg, req_ready}, {59'h0, 4'd0, 1'b1});
        chk("rst_mid_rsp", {63'h0, rsp_valid}, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        ack_en = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            seen = seen | rsp_valid | wb_stb_o;
        end
        chk("rst_no_rsp", {63'h0, seen}, 64'h0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_xip_seq.md
SPI_XIP_SEQ -- requirements
Module: spi_xip_seq

Interface
REQ-001 Parameter DIVIDER, default 32'h1: value written to the SPI master DIVIDER register.
REQ-002 Parameter SS_MASK, default 32'h1: value written to the SS register to select the flash.
REQ-003 Parameter POLL_MAX, default 1023: maximum CTRL polls before timeout.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  flash read request.
REQ-007 req_ready  out  1  request accepted on req_valid && req_ready.
REQ-008 req_addr  in  24  flash byte address.
REQ-009 rsp_valid  out  1  read data available.
REQ-010 rsp_ready  in  1  consumer accepts the response.
REQ-011 rsp_data  out  32  read word.
REQ-012 rsp_err  out  1  timeout flag qualifying rsp_valid.
REQ-013 wb_adr_o / wb_dat_o / wb_sel_o  out  5 / 32 / 4  Wishbone master address, write data and byte select to the SPI master.
REQ-014 wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone master control.
REQ-015 wb_ack_i  in  1; wb_dat_i  in  32: Wishbone slave acknowledge and read data.

Function
REQ-016 States SHALL be IDLE, WR_TX1, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX0, CLR_SS, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; on acceptance, req_addr is latched and the state moves to WR_TX1.
REQ-018 Each bus state SHALL assert stb/cyc with fixed fields and hold them until wb_ack_i, then drop stb/cyc for at least one cycle before the next access.
REQ-019 Accesses (adr, dat, we, sel=4'hF for writes and 4'h0 for reads):
  - WR_TX1: 0x04, {8'h03, addr}, we=1.
  - WR_DIV: 0x14, DIVIDER, we=1.
  - WR_SS: 0x18, SS_MASK, we=1.
  - WR_CTRL: 0x10, 32'h00000140 (GO_BSY=1, CHAR_LEN=64), we=1.
  - POLL: 0x10, we=0.
  - RD_RX0: 0x00, we=0.
  - CLR_SS: 0x18, 32'h0, we=1.
REQ-020 In POLL, on each ack: if wb_dat_i[8]==0, go to RD_RX0; otherwise increment the 10-bit poll counter and re-poll.
REQ-021 When a poll ack arrives with wb_dat_i[8]==1 and the counter equals POLL_MAX, the block SHALL set the error flag and go to CLR_SS, skipping RD_RX0.
REQ-022 On the RD_RX0 ack, wb_dat_i SHALL be captured into the data register, then the state moves to CLR_SS.
REQ-023 After the CLR_SS ack, the state SHALL move to RESP with rsp_valid=1.
REQ-024 rsp_valid, rsp_data and rsp_err SHALL stay stable until rsp_ready; on rsp_valid && rsp_ready, the state returns to IDLE in the next cycle.
REQ-025 On timeout, rsp_data SHALL be 32'h0 and rsp_err=1; otherwise rsp_err=0.
REQ-026 The poll counter SHALL clear on request acceptance and SHALL never wrap.
REQ-027 A wb_ack_i received outside an active stb/cyc SHALL be ignored.
REQ-028 A req_valid arriving while not in IDLE SHALL be held off (req_ready=0) and SHALL NOT be dropped.
REQ-029 Minimum latency from acceptance to rsp_valid SHALL be 7 accesses × (1 request cycle + 1 gap cycle) with a single-cycle ack.

Reset
REQ-030 Asynchronous reset SHALL force IDLE and set all outputs to 0 except req_ready=1; the poll counter and the data/error registers clear.
REQ-031 A reset asserted mid-transaction SHALL drop stb/cyc immediately and SHALL NOT produce a response.

Configuration
REQ-032 Macro SPI_XIP_BSWAP_EN defined: rsp_data = {d[7:0], d[15:8], d[23:16], d[31:24]} of the captured RX0 word.
REQ-033 Macro SPI_XIP_BSWAP_EN undefined: rsp_data = the captured word unchanged; the timeout data is 0 in both builds.

Verification
REQ-034 Request addr 24'h000100 with a single-cycle ack model -> accesses in the REQ-019 order; TX1 data 32'h03000100; CTRL data 32'h00000140.
REQ-035 Model returns CTRL bit8=1 for 3 polls, then 0; RX0=32'h11223344 -> exactly 4 POLL accesses; rsp_data=32'h11223344 (32'h44332211 with BSWAP), rsp_err=0.
REQ-036 Model holds CTRL bit8=1 permanently with POLL_MAX=4 -> 5 polls, CLR_SS issued, rsp_err=1, rsp_data=0.
REQ-037 rsp_ready held low for 10 cycles, plus a second req_valid pending -> response stable throughout, req_ready=0, second request accepted one cycle after the handshake completes.
REQ-038 Reset asserted during WR_CTRL with ack pending -> stb/cyc=0 in the same cycle, IDLE, no rsp_valid.
